code_loader: RTL
================

Name: code_loader

Overview:
- Writer-side front end for the code_storage instruction memory.
- Accepts a byte stream from the host link with a valid/ready handshake.
- Decodes the stream into load and configure commands, then drives code_storage's write port (is_write, write_line, write_data) and its loop-register update strobes.
- Raises busy while a command is in flight so the core can hold its enable low.

Parameters:
- code_size, 12, width of one code word; must be ≤16.
- max_code_line, 100, highest valid line index, matching code_storage; lines > max_code_line are rejected.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle; a transfer occurs when in_valid && in_ready.
- is_write  output  1  one-cycle write strobe to code_storage.
- write_line  output  32  target line.
- write_data  output  code_size  word to write.
- code_reset_address  output  32  loop address value.
- update_code_reset_address  output  1  one-cycle strobe.
- code_reset_count  output  32  loop count value.
- update_code_reset_count  output  1  one-cycle strobe.
- busy  output  1  high from opcode accept until DONE.
- done  output  1  one-cycle pulse at command completion.
- error  output  1  sticky error flag; cleared only by reset_n.

Behaviour:
- reset_n low (asynchronous): state=IDLE. All outputs 0 except in_ready=1. Internal line/count/shift registers are 0.
- All outputs are registered.
- Opcodes, taken from the first byte in IDLE:
  - 0xA1 LOAD: 4-byte start line (big-endian), then 2-byte word count N (big-endian), then N words of 2 bytes each (big-endian). Only bits [code_size-1:0] of each word are used; the upper bits are ignored.
  - 0xA2 SET_ADDR: 4-byte value (big-endian).
  - 0xA3 SET_COUNT: 4-byte value (big-endian).
  - Any other byte: error<=1, stay in IDLE, byte consumed, no done pulse.
- States: IDLE, ADDR, COUNT, DATA_HI, DATA_LO, WRITE, ARG, APPLY, DONE.
- IDLE: on a valid opcode, busy<=1 and go to ADDR (0xA1) or ARG (0xA2/0xA3).
- ADDR: shift in 4 bytes, then go to COUNT.
- COUNT: shift in 2 bytes. If N==0 go to DONE, else go to DATA_HI.
- DATA_HI: accept 1 byte, go to DATA_LO.
- DATA_LO: accept 1 byte, go to WRITE.
- WRITE: in_ready=0 for exactly this one cycle.
  - is_write=1, write_line=line, write_data=word, all asserted in the cycle after the DATA_LO byte is accepted.
  - If line > max_code_line: suppress is_write and set error<=1. The word is still consumed.
  - Then line<=line+1 (32-bit wrap allowed) and remaining<=remaining-1.
  - If remaining becomes 0 go to DONE, else go to DATA_HI.
- ARG: shift in 4 bytes, then go to APPLY.
- APPLY: in_ready=0. Drive the value onto code_reset_address or code_reset_count according to the opcode, pulse the matching update_* for one cycle, then go to DONE.
- Value hold: code_reset_address and code_reset_count hold their last values between commands.
- DONE: in_ready=0, done=1 for one cycle, busy<=0, then go to IDLE.
- Latency: the write strobe follows the accepted low byte by exactly 1 cycle. Minimum cycles for a 1-word load = 1 (opcode) + 6 + 2 + 1 (WRITE) + 1 (DONE).
- Gaps: in_valid low mid-command stalls the current state indefinitely; there is no timeout.
- reset_n asserted mid-command aborts immediately. A partial load leaves earlier words written and performs no further writes.
- update_* strobes and is_write are never asserted in the same cycle.

Decomposition:
- Shared package code_pkg: opcode constants (OP_LOAD=8'hA1, OP_SET_ADDR=8'hA2, OP_SET_COUNT=8'hA3) and the state enum type. code_storage and the host-side model import the same package.
- One natural sub-module, byte_shift_accum: shifts big-endian bytes into a 32-bit register and signals when a programmable count of 1/2/4 bytes has been collected. It is reused by ADDR, COUNT, the DATA pair and ARG.

Test Plan:
- Load: stream A1 00 00 00 05 00 02 0A BC 01 23 → is_write at line 5 with data 0xABC, then line 6 with 0x123; done pulses once; error=0.
- Set address: stream A2 00 00 00 07 → code_reset_address=7 with one update_code_reset_address pulse. Then A3 00 00 00 03 → code_reset_count=3 with one update_code_reset_count pulse.
- Bad opcode and out-of-range write: byte 0x55 → error=1, state IDLE, busy=0. Separately, A1 00 00 00 64 00 02 … → line 100 is written; line 101 is suppressed with error=1, and done still pulses.
- Zero-length load: stream A1 00 00 00 00 00 00 → no is_write, done pulses, busy drops.
- Stalls and handshake: in_valid toggled 1-of-3 cycles during a 3-word load → same writes as back-to-back streaming. in_ready is low exactly during the WRITE and DONE cycles.
- Reset mid-command: reset_n pulsed low after the DATA_HI byte of word 2 → outputs clear asynchronously, word 2 is not written, and a subsequent clean load works.

Source files
------------

// File: rtl/code_pkg.sv
// rtl/code_pkg.sv - shared opcodes and loader state type
// Purpose: opcode constants and the loader FSM state enum, shared by the
// loader, code_storage and the host-side model.
// Ports: none (package).
package code_pkg;

  localparam logic [7:0] OP_LOAD      = 8'hA1;
  localparam logic [7:0] OP_SET_ADDR  = 8'hA2;
  localparam logic [7:0] OP_SET_COUNT = 8'hA3;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    COUNT,
    DATA_HI,
    DATA_LO,
    WRITE,
    ARG,
    APPLY,
    DONE
  } state_t;

endpackage

// File: rtl/byte_shift_accum.sv
// rtl/byte_shift_accum.sv - big-endian byte accumulator with 1/2/4-byte framing
// Purpose: shifts bytes MSB-first into a 32-bit value and flags the byte that
// completes a field of num_bytes bytes.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   shift_en            accept byte_in this cycle
//   byte_in[7:0]        incoming byte
//   num_bytes[2:0]      field length (1, 2 or 4)
//   value_next[31:0]    accumulated value including byte_in (valid with complete)
//   complete            byte_in is the last byte of the field
module byte_shift_accum (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  input  logic [2:0]  num_bytes,
  output logic [31:0] value_next,
  output logic        complete
);

  // Only the three most recent bytes need storing; the fourth is byte_in.
  logic [23:0] acc;
  logic [1:0]  cnt;

  assign value_next = {acc, byte_in};
  assign complete   = shift_en && ({1'b0, cnt} == (num_bytes - 3'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      acc <= value_next[23:0];
      cnt <= complete ? 2'd0 : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/code_loader.sv
// rtl/code_loader.sv - byte-stream command decoder driving code_storage writes
// Purpose: decodes LOAD / SET_ADDR / SET_COUNT commands from a valid/ready
// byte stream and drives the code_storage write port and loop registers.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    host byte stream
//   is_write/write_line/write_data   code_storage write port (1-cycle strobe)
//   code_reset_address + update_code_reset_address   loop address and strobe
//   code_reset_count + update_code_reset_count       loop count and strobe
//   busy, done, error            command in flight, completion pulse, sticky error
module code_loader
  import code_pkg::*;
#(
  parameter int code_size     = 12,
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic [31:0]          code_reset_address,
  output logic                 update_code_reset_address,
  output logic [31:0]          code_reset_count,
  output logic                 update_code_reset_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [31:0] MAX_LINE = 32'(max_code_line);

  state_t      state, next_state;
  logic [31:0] line;
  logic [15:0] remaining;
  logic        op_count;
  logic        xfer;
  logic        shift_en;
  logic [2:0]  num_bytes;
  logic [31:0] acc_value;
  logic        acc_complete;

  assign xfer = in_valid && in_ready;

  byte_shift_accum u_accum (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en   (shift_en),
    .byte_in    (in_data),
    .num_bytes  (num_bytes),
    .value_next (acc_value),
    .complete   (acc_complete)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    num_bytes  = 3'd4;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (in_data == OP_LOAD) next_state = ADDR;
          else if (in_data == OP_SET_ADDR || in_data == OP_SET_COUNT) next_state = ARG;
        end
      end
      ADDR: begin
        shift_en = xfer;
        if (acc_complete) next_state = COUNT;
      end
      COUNT: begin
        num_bytes = 3'd2;
        shift_en  = xfer;
        if (acc_complete) next_state = (acc_value[15:0] == 16'd0) ? DONE : DATA_HI;
      end
      // The data word is framed as one 2-byte field spanning both states.
      DATA_HI: begin
        num_bytes = 3'd2;
        shift_en  = xfer;
        if (xfer) next_state = DATA_LO;
      end
      DATA_LO: begin
        num_bytes = 3'd2;
        shift_en  = xfer;
        if (xfer) next_state = WRITE;
      end
      WRITE:   next_state = (remaining == 16'd1) ? DONE : DATA_HI;
      ARG: begin
        shift_en = xfer;
        if (acc_complete) next_state = APPLY;
      end
      APPLY:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so each strobe lines up with the
  // state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready                  <= 1'b1;
      is_write                  <= 1'b0;
      write_line                <= '0;
      write_data                <= '0;
      code_reset_address        <= '0;
      update_code_reset_address <= 1'b0;
      code_reset_count          <= '0;
      update_code_reset_count   <= 1'b0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      error                     <= 1'b0;
      line                      <= '0;
      remaining                 <= '0;
      op_count                  <= 1'b0;
    end else begin
      in_ready                  <= !(next_state inside {WRITE, APPLY, DONE});
      busy                      <= (next_state != IDLE);
      done                      <= (next_state == DONE);
      is_write                  <= 1'b0;
      update_code_reset_address <= 1'b0;
      update_code_reset_count   <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (in_data == OP_SET_ADDR || in_data == OP_SET_COUNT || in_data == OP_LOAD)
              op_count <= (in_data == OP_SET_COUNT);
            else
              error <= 1'b1;
          end
        end
        ADDR:  if (acc_complete) line <= acc_value;
        COUNT: if (acc_complete) remaining <= acc_value[15:0];
        DATA_LO: begin
          if (xfer) begin
            write_line <= line;
            write_data <= acc_value[code_size-1:0];
            if (line <= MAX_LINE) is_write <= 1'b1;
            else                  error    <= 1'b1;
          end
        end
        WRITE: begin
          line      <= line + 32'd1;
          remaining <= remaining - 16'd1;
        end
        ARG: begin
          if (acc_complete) begin
            if (op_count) begin
              code_reset_count        <= acc_value;
              update_code_reset_count <= 1'b1;
            end else begin
              code_reset_address        <= acc_value;
              update_code_reset_address <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
